// File: rtl/asivp_pkg.sv
// asivp_pkg: shared geometry, stage record and constants for the vector issue pipe
// Ports: none (package)
// The lane geometry here sets the payload and register-index widths used by
// the interface, the pipe and the hazard unit.
package asivp_pkg;
    localparam int LANES      = 4;
    localparam int LANE_W     = 8;
    localparam int REG_ADDR_W = 4;
    localparam int PAYLOAD_W  = LANES * LANE_W;
    localparam logic [REG_ADDR_W-1:0] VREG_ZERO = '0;
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [PAYLOAD_W-1:0]  payload;
    } vip_stage_t;
endpackage

// File: rtl/vector_issue_pipe_if.sv
// vector_issue_pipe_if: decode-side handshake, branch flush and writeback-boundary bus
// Ports (signals):
//   if_valid/if_ready        decode offer / issue accept
//   if_rs1/if_rs2/if_rd/if_we/if_payload  decoded instruction
//   br_taken                 branch resolved taken at the last stage
//   out_valid/out_rd/out_we/out_payload   last-stage contents
//   stall_cnt                saturating count of cycles offered but not accepted
// Modports: master (decode/writeback side), slave (the pipe).
interface vector_issue_pipe_if #(
    parameter int CNT_W = 16
);
    import asivp_pkg::*;
    logic                  if_valid;
    logic                  if_ready;
    logic [REG_ADDR_W-1:0] if_rs1;
    logic [REG_ADDR_W-1:0] if_rs2;
    logic [REG_ADDR_W-1:0] if_rd;
    logic                  if_we;
    logic [PAYLOAD_W-1:0]  if_payload;
    logic                  br_taken;
    logic                  out_valid;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_we;
    logic [PAYLOAD_W-1:0]  out_payload;
    logic [CNT_W-1:0]      stall_cnt;
    modport master (
        output if_valid, if_rs1, if_rs2, if_rd, if_we, if_payload, br_taken,
        input  if_ready, out_valid, out_rd, out_we, out_payload, stall_cnt
    );
    modport slave (
        input  if_valid, if_rs1, if_rs2, if_rd, if_we, if_payload, br_taken,
        output if_ready, out_valid, out_rd, out_we, out_payload, stall_cnt
    );
endinterface

// File: rtl/vector_hazard_unit.sv
// vector_hazard_unit: RAW comparator of the incoming sources against in-flight writers
// Ports:
//   req_valid  in  decode offers an instruction
//   rs1, rs2   in  incoming source registers
//   wr_live    in  per checked stage: valid && we
//   wr_rd      in  per checked stage: destination register
//   hazard     out some live writer targets rs1 or rs2 (register 0 never counts)
module vector_hazard_unit
    import asivp_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                           req_valid,
    input  logic [REG_ADDR_W-1:0]          rs1,
    input  logic [REG_ADDR_W-1:0]          rs2,
    input  logic [N-1:0]                   wr_live,
    input  logic [N-1:0][REG_ADDR_W-1:0]   wr_rd,
    output logic                           hazard
);
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < N; k++)
            hazard = hazard || (wr_live[k] && wr_rd[k] != VREG_ZERO &&
                                (wr_rd[k] == rs1 || wr_rd[k] == rs2));
        hazard = hazard && req_valid;
    end
endmodule

// File: rtl/vector_issue_pipe.sv
// vector_issue_pipe: in-order issue with RAW interlock, branch flush and a DEPTH-stage chain
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    vector_issue_pipe_if.slave (decode handshake, br_taken, last-stage outputs, stall_cnt)
// Parameters: DEPTH (>=2) stages after issue, CNT_W stall counter width
//   (must match the interface's CNT_W).
// Configuration macro: VIP_WB_BYPASS_EN -- when defined the register file is
//   write-first, so the last stage is left out of the hazard check.
module vector_issue_pipe
    import asivp_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    vector_issue_pipe_if.slave bus
);
`ifdef VIP_WB_BYPASS_EN
    localparam int HZ_N = DEPTH - 1;
`else
    localparam int HZ_N = DEPTH;
`endif
    vip_stage_t                      st_q [DEPTH];
    vip_stage_t                      st_d [DEPTH];
    logic [CNT_W-1:0]                stall_cnt_q, stall_cnt_d;
    logic [HZ_N-1:0]                 wr_live;
    logic [HZ_N-1:0][REG_ADDR_W-1:0] wr_rd;
    logic                            hazard, flush, accept;
    for (genvar i = 0; i < HZ_N; i++) begin : g_hz
        assign wr_live[i] = st_q[i].valid && st_q[i].we;
        assign wr_rd[i]   = st_q[i].rd;
    end
    vector_hazard_unit #(.N(HZ_N)) u_hz (
        .req_valid (bus.if_valid),
        .rs1       (bus.if_rs1),
        .rs2       (bus.if_rs2),
        .wr_live   (wr_live),
        .wr_rd     (wr_rd),
        .hazard    (hazard)
    );
    // br_taken blocks issue even when it is ignored for lack of a live last stage
    assign bus.if_ready = rst_n && !hazard && !bus.br_taken;
    always_comb begin
        flush  = bus.br_taken && st_q[DEPTH-1].valid;
        accept = bus.if_valid && bus.if_ready;
        st_d[0] = accept ? '{valid: 1'b1, we: bus.if_we, rd: bus.if_rd, payload: bus.if_payload} : '0;
        // a flush kills everything younger than the retiring last stage
        for (int k = 1; k < DEPTH; k++) begin
            st_d[k]       = st_q[k-1];
            st_d[k].valid = st_q[k-1].valid && !flush;
            st_d[k].we    = st_q[k-1].we && !flush;
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(bus.if_valid && !bus.if_ready && stall_cnt_q != '1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) st_q[k] <= '0;
            stall_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign bus.out_valid   = st_q[DEPTH-1].valid;
    assign bus.out_we      = st_q[DEPTH-1].we;
    assign bus.out_rd      = st_q[DEPTH-1].rd;
    assign bus.out_payload = st_q[DEPTH-1].payload;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_vector_issue_pipe.sv
// tb_vector_issue_pipe: scoreboard bench for vector_issue_pipe
module tb_vector_issue_pipe;
    import asivp_pkg::*;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;
`ifdef VIP_WB_BYPASS_EN
    localparam int RAW_STALL = DEPTH - 1;
`else
    localparam int RAW_STALL = DEPTH;
`endif
    typedef struct {
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic [PAYLOAD_W-1:0]  pl;
        int                    out_cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb [$];
    vector_issue_pipe_if #(.CNT_W(CNT_W)) bus ();
    vector_issue_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.out_valid && sb.size() == 0) begin
            check("out_valid_unexpected", bus.out_valid, 1'b0);
        end else if (bus.out_valid) begin
            e = sb.pop_front();
            check("out_rd", bus.out_rd, e.rd);
            check("out_we", bus.out_we, e.we);
            check("out_payload", bus.out_payload, e.pl);
            check("out_cycle", cyc, e.out_cyc);
        end else begin
            check("out_we_idle", bus.out_we, 1'b0);
            if (sb.size() > 0 && sb[0].out_cyc <= cyc) begin
                check("out_valid_due", bus.out_valid, 1'b1);
                sb.delete(0);
            end
        end
    end
    task automatic issue(input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs1,
                         input logic [REG_ADDR_W-1:0] rs2, input logic we,
                         input logic [PAYLOAD_W-1:0] pl, output int waits);
        exp_t e;
        bus.if_valid = 1'b1;
        bus.if_rd = rd;
        bus.if_rs1 = rs1;
        bus.if_rs2 = rs2;
        bus.if_we = we;
        bus.if_payload = pl;
        waits = 0;
        @(negedge clk);
        while (!bus.if_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (bus.if_ready) begin
            e = '{rd, we, pl, cyc + DEPTH};
            sb.push_back(e);
        end else begin
            check("issue_timeout", bus.if_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.if_valid = 1'b0;
    endtask
    task automatic do_reset();
        bus.if_valid = 1'b1;
        bus.br_taken = 1'b0;
        bus.if_rd = '0;
        bus.if_rs1 = '0;
        bus.if_rs2 = '0;
        bus.if_we = 1'b0;
        bus.if_payload = '0;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_ready", bus.if_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_we", bus.out_we, 1'b0);
        check("rst_out_rd", bus.out_rd, '0);
        check("rst_out_payload", bus.out_payload, '0);
        check("rst_stall_cnt", bus.stall_cnt, '0);
        bus.if_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic drain(input string name);
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask
    initial begin
        int w, tot;
        do_reset();
        tot = 0;
        for (int i = 1; i <= 6; i++) begin
            issue(REG_ADDR_W'(i), 4'd0, 4'd0, 1'b1, PAYLOAD_W'(32'h1111_1111 * i), w);
            tot += w;
        end
        check("t1_waits", tot, 0);
        drain("t1_drained");
        check("t1_stall_cnt", bus.stall_cnt, 0);
        do_reset();
        issue(4'd5, 4'd0, 4'd0, 1'b1, 32'hA5A5_0001, w);
        check("t2_a_waits", w, 0);
        issue(4'd7, 4'd5, 4'd0, 1'b1, 32'hB0B0_0002, w);
        check("t2_raw_rs1_waits", w, RAW_STALL);
        check("t2_stall_cnt_rs1", bus.stall_cnt, RAW_STALL);
        issue(4'd6, 4'd0, 4'd0, 1'b1, 32'hC3C3_0003, w);
        check("t2_c_waits", w, 0);
        issue(4'd8, 4'd1, 4'd6, 1'b1, 32'hD4D4_0004, w);
        check("t2_raw_rs2_waits", w, RAW_STALL);
        issue(4'd2, 4'd0, 4'd0, 1'b0, 32'hE5E5_0005, w);
        issue(4'd3, 4'd2, 4'd2, 1'b1, 32'hF6F6_0006, w);
        check("t2_no_we_waits", w, 0);
        check("t2_stall_cnt_total", bus.stall_cnt, 2 * RAW_STALL);
        drain("t2_drained");
        do_reset();
        for (int i = 1; i <= 3; i++)
            issue(REG_ADDR_W'(i), 4'd0, 4'd0, 1'b1, PAYLOAD_W'(32'hC0DE_0000 + i), w);
        bus.br_taken = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_rd = 4'd9;
        bus.if_rs1 = 4'd0;
        bus.if_rs2 = 4'd0;
        bus.if_we = 1'b1;
        @(negedge clk);
        check("t3_ready_during_flush", bus.if_ready, 1'b0);
        check("t3_out_valid_at_flush", bus.out_valid, 1'b1);
        while (sb.size() > 0 && sb[sb.size()-1].out_cyc > cyc) sb.delete(sb.size() - 1);
        @(posedge clk);
        #1;
        bus.br_taken = 1'b0;
        bus.if_valid = 1'b0;
        check("t3_stall_cnt", bus.stall_cnt, 1);
        repeat (2) begin
            @(negedge clk);
            check("t3_flushed_out_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        issue(4'd9, 4'd0, 4'd0, 1'b1, 32'hD00D_0009, w);
        check("t3_after_flush_waits", w, 0);
        drain("t3_drained");
        do_reset();
        issue(4'd0, 4'd0, 4'd0, 1'b1, 32'h0000_00AA, w);
        issue(4'd4, 4'd0, 4'd0, 1'b1, 32'h0000_00BB, w);
        check("t4_rd0_waits", w, 0);
        check("t4_stall_cnt", bus.stall_cnt, 0);
        drain("t4_drained");
        do_reset();
        for (int i = 1; i <= 3; i++)
            issue(REG_ADDR_W'(i + 10), 4'd0, 4'd0, 1'b1, PAYLOAD_W'(32'h5EED_0000 + i), w);
        #2;
        check("t5_out_valid_before", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_async_out_valid", bus.out_valid, 1'b0);
        check("t5_async_out_we", bus.out_we, 1'b0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(4'd8, 4'd0, 4'd0, 1'b1, 32'hFEED_0008, w);
        check("t5_after_reset_waits", w, 0);
        drain("t5_drained");
        do_reset();
        bus.if_valid = 1'b1;
        bus.br_taken = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("t6_stall_cnt_14", bus.stall_cnt, 14);
        repeat (6) @(posedge clk);
        #1;
        check("t6_stall_cnt_sat", bus.stall_cnt, 15);
        bus.if_valid = 1'b0;
        bus.br_taken = 1'b0;
        drain("t6_drained");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
